qsfp_sb_multi_port_mgr: RTL

- Parametrised successor to the single-cage QSFP sideband sequencer. Drives one I2C command engine over the standard IO_CONTROL/IO_ADDR/IO_WDATA/IO_RDATA handshake.
- Services NUM_PORTS cages in one pass. Per port: mux select, then either init or scan.
- Adds per-port present/interrupt status, host-controlled LPMODE, and a command timeout with per-port error flags.
- Sits between the board-management scheduler (start/complete) and the shared I2C master.

---
 rtl/qsfp_sb_multi_port_mgr.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/qsfp_sb_multi_port_mgr.sv
// qsfp_sb_multi_port_mgr
// Multi-cage QSFP sideband sequencer. On each pass it walks every cage,
// selects the cage through two I2C mux writes and then either configures the
// sideband IO expander (init pass) or reads it back and reacts to module
// insertion/removal (scan pass). All I2C traffic goes through one shared
// command engine using a single ISSUE -> WAIT -> GAP sequence, with a WAIT
// timeout that flags the offending port and moves on to the next one.
module qsfp_sb_multi_port_mgr #(
    parameter int unsigned                NUM_PORTS      = 2,
    parameter logic [8*NUM_PORTS-1:0]     MUX0_VALUES    = {8'h00, 8'h01},
    parameter logic [8*NUM_PORTS-1:0]     MUX1_VALUES    = {8'h01, 8'h00},
    parameter logic [7:0]                 SB_DEV_ID      = 8'h40,
    parameter logic [15:0]                DELAY_CYCLES   = 16'h0400,
    parameter logic [19:0]                TIMEOUT_CYCLES = 20'hF_FFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 init,
    input  logic [NUM_PORTS-1:0] lpmode,
    output logic                 complete,
    output logic                 busy,
    output logic [NUM_PORTS-1:0] port_present,
    output logic [NUM_PORTS-1:0] port_intl,
    output logic [NUM_PORTS-1:0] port_err,
    output logic [7:0]           dbg_cstate,
    output logic                 IO_CONTROL_PULSE,
    output logic                 IO_CONTROL_RW,
    output logic [7:0]           IO_CONTROL_ID,
    output logic [7:0]           IO_ADDR_ADDR,
    output logic [7:0]           IO_WDATA_WDATA,
    input  logic [7:0]           IO_RDATA_RDATA,
    input  logic                 IO_CONTROL_CMPLT
);

    localparam int unsigned    PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [PW-1:0]  LAST_PORT = PW'(NUM_PORTS - 1);

    // I2C addresses of the two cage-select muxes.
    localparam logic [7:0] MUX0_ID = 8'hE0;
    localparam logic [7:0] MUX1_ID = 8'hE4;

    // Sideband IO expander registers: input, output, configuration.
    localparam logic [7:0] REG_IN  = 8'h00;
    localparam logic [7:0] REG_OUT = 8'h01;
    localparam logic [7:0] REG_CFG = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Which command the shared ISSUE/WAIT/GAP sequence is currently running.
    typedef enum logic [2:0] {
        CMD_MUX0 = 3'd0,
        CMD_MUX1 = 3'd1,
        CMD_OUT  = 3'd2,
        CMD_CFG  = 3'd3,
        CMD_READ = 3'd4,
        CMD_EN   = 3'd5
    } cmd_t;

    state_t               r_state;
    state_t               w_next_state;
    cmd_t                 r_cmd;
    logic [PW-1:0]        r_port;
    logic                 r_init;
    logic                 r_port_done;
    logic                 r_en_insert;
    logic [19:0]          r_wait_cnt;
    logic [15:0]          r_gap_cnt;
    logic [NUM_PORTS-1:0] r_prsnt_l;
    logic [NUM_PORTS-1:0] r_present;
    logic [NUM_PORTS-1:0] r_intl;
    logic [NUM_PORTS-1:0] r_err;
    logic                 r_pulse;
    logic                 r_rw;
    logic [7:0]           r_id;
    logic [7:0]           r_addr;
    logic [7:0]           r_wdata;

    logic                 w_accept;
    logic                 w_cmplt;
    logic                 w_timeout;
    logic                 w_gap_done;
    logic                 w_last_port;
    logic [7:0]           w_mux0_val;
    logic [7:0]           w_mux1_val;
    logic [7:0]           w_en_wdata;
    logic                 w_unused_rd;

    assign w_mux0_val  = MUX0_VALUES[{r_port, 3'b000} +: 8];
    assign w_mux1_val  = MUX1_VALUES[{r_port, 3'b000} +: 8];
    // Insertion enables the cage with the host's LPMODE choice in bit 0.
    assign w_en_wdata  = r_en_insert ? {7'h08, lpmode[r_port]} : 8'h00;
    // Only the INTL (bit 1) and MODPRSTL (bit 2) inputs matter here.
    assign w_unused_rd = ^{IO_RDATA_RDATA[7:3], IO_RDATA_RDATA[0]};

    assign busy             = (r_state != ST_IDLE);
    assign complete         = (r_state == ST_DONE);
    assign dbg_cstate       = {5'd0, r_state};
    assign port_present     = r_present;
    assign port_intl        = r_intl;
    assign port_err         = r_err;
    assign IO_CONTROL_PULSE = r_pulse;
    assign IO_CONTROL_RW    = r_rw;
    assign IO_CONTROL_ID    = r_id;
    assign IO_ADDR_ADDR     = r_addr;
    assign IO_WDATA_WDATA   = r_wdata;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and the per-cycle decisions shared with the datapath.
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_cmplt      = 1'b0;
        w_timeout    = 1'b0;
        w_gap_done   = ({1'b0, r_gap_cnt} + 17'd1) >= {1'b0, DELAY_CYCLES};
        w_last_port  = (r_port == LAST_PORT);
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion on the expiry cycle still counts as success.
                if (IO_CONTROL_CMPLT) begin
                    w_cmplt      = 1'b1;
                    w_next_state = ST_GAP;
                end else if (r_wait_cnt == TIMEOUT_CYCLES) begin
                    w_timeout    = 1'b1;
                    w_next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_gap_done) begin
                    w_next_state = (r_port_done && w_last_port) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Command datapath: command selection, counters, I2C fields, port status.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd       <= CMD_MUX0;
            r_port      <= '0;
            r_init      <= 1'b0;
            r_port_done <= 1'b0;
            r_en_insert <= 1'b0;
            r_wait_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_prsnt_l   <= '1;
            r_present   <= '0;
            r_intl      <= '0;
            r_err       <= '0;
            r_pulse     <= 1'b0;
            r_rw        <= 1'b0;
            r_id        <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_init      <= init;
                        r_port      <= '0;
                        r_cmd       <= CMD_MUX0;
                        r_port_done <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    r_pulse    <= 1'b1;
                    r_wait_cnt <= '0;
                    case (r_cmd)
                        CMD_MUX0: {r_rw, r_id, r_addr, r_wdata} <= {1'b0, MUX0_ID, w_mux0_val, w_mux0_val};
                        CMD_MUX1: {r_rw, r_id, r_addr, r_wdata} <= {1'b0, MUX1_ID, w_mux1_val, w_mux1_val};
                        CMD_OUT:  {r_rw, r_id, r_addr, r_wdata} <= {1'b0, SB_DEV_ID, REG_OUT, 8'h00};
                        CMD_CFG:  {r_rw, r_id, r_addr, r_wdata} <= {1'b0, SB_DEV_ID, REG_CFG, 8'h06};
                        CMD_READ: {r_rw, r_id, r_addr, r_wdata} <= {1'b1, SB_DEV_ID, REG_IN, 8'h00};
                        CMD_EN:   {r_rw, r_id, r_addr, r_wdata} <= {1'b0, SB_DEV_ID, REG_OUT, w_en_wdata};
                        default:  {r_rw, r_id, r_addr, r_wdata} <= '0;
                    endcase
                end
                ST_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 20'd1;
                    r_gap_cnt  <= '0;
                    if (w_cmplt) begin
                        case (r_cmd)
                            CMD_MUX0: r_cmd <= CMD_MUX1;
                            CMD_MUX1: r_cmd <= r_init ? CMD_OUT : CMD_READ;
                            CMD_OUT:  r_cmd <= CMD_CFG;
                            CMD_CFG: begin
                                r_port_done       <= 1'b1;
                                r_prsnt_l[r_port] <= 1'b1;
                                r_err[r_port]     <= 1'b0;
                            end
                            CMD_READ: begin
                                // NOTE: non-blocking updates mean the edge test
                                // below still sees the previous r_prsnt_l value,
                                // which is exactly what insertion/removal needs.
                                r_intl[r_port]    <= ~IO_RDATA_RDATA[1];
                                r_err[r_port]     <= 1'b0;
                                r_prsnt_l[r_port] <= IO_RDATA_RDATA[2];
                                r_present[r_port] <= ~IO_RDATA_RDATA[2];
                                if (r_prsnt_l[r_port] && !IO_RDATA_RDATA[2]) begin
                                    r_en_insert <= 1'b1;
                                    r_cmd       <= CMD_EN;
                                end else if (!r_prsnt_l[r_port] && IO_RDATA_RDATA[2]) begin
                                    r_en_insert <= 1'b0;
                                    r_cmd       <= CMD_EN;
                                end else begin
                                    r_port_done <= 1'b1;
                                end
                            end
                            default: r_port_done <= 1'b1;
                        endcase
                    end else if (w_timeout) begin
                        // Abandon the rest of this port; its status stays as is.
                        r_err[r_port] <= 1'b1;
                        r_port_done   <= 1'b1;
                    end
                end
                ST_GAP: begin
                    r_gap_cnt <= r_gap_cnt + 16'd1;
                    if (w_gap_done && r_port_done) begin
                        r_port_done <= 1'b0;
                        r_cmd       <= CMD_MUX0;
                        if (w_last_port) begin
                            // Leave the bus fields quiet between passes.
                            r_rw    <= 1'b0;
                            r_id    <= '0;
                            r_addr  <= '0;
                            r_wdata <= '0;
                        end else begin
                            r_port <= r_port + PW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
